// File: rtl/tag_resolver_if.sv
// -----------------------------------------------------------------------------
// tag_resolver_if
// Purpose : bundles the tag resolver's control inputs, the held tag mask and
//           the address valid/ready handshake into one connection.
// Signals : tags_in, capture, accumulate, start, abort, out_ready  (into block)
//           tag_reg, any_match, out_valid, out_addr, busy, done   (from block)
//           match_count (from block, only when TAG_RESOLVER_COUNT_EN is set)
// Modports: slave  - the tag_resolver itself
//           master - whoever drives commands and consumes addresses
// Build option: TAG_RESOLVER_COUNT_EN adds the match_count signal.
// -----------------------------------------------------------------------------
interface tag_resolver_if #(
  parameter int CELL_QUANT = 512
);
  localparam int ADDR_W = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1;

  logic [CELL_QUANT-1:0] tags_in;
  logic                  capture;
  logic                  accumulate;
  logic                  start;
  logic                  abort;
  logic                  out_ready;
  logic [CELL_QUANT-1:0] tag_reg;
  logic                  any_match;
  logic                  out_valid;
  logic [ADDR_W-1:0]     out_addr;
  logic                  busy;
  logic                  done;
`ifdef TAG_RESOLVER_COUNT_EN
  logic [ADDR_W:0]       match_count;

  modport slave (
    input  tags_in, capture, accumulate, start, abort, out_ready,
    output tag_reg, any_match, out_valid, out_addr, busy, done, match_count
  );
  modport master (
    output tags_in, capture, accumulate, start, abort, out_ready,
    input  tag_reg, any_match, out_valid, out_addr, busy, done, match_count
  );
`else
  modport slave (
    input  tags_in, capture, accumulate, start, abort, out_ready,
    output tag_reg, any_match, out_valid, out_addr, busy, done
  );
  modport master (
    output tags_in, capture, accumulate, start, abort, out_ready,
    input  tag_reg, any_match, out_valid, out_addr, busy, done
  );
`endif
endinterface

// File: rtl/tag_resolver.sv
// -----------------------------------------------------------------------------
// tag_resolver
// Purpose : captures the CAM tag vector into a held mask (used as the
//           parallel-write enable mask), then walks the set tags lowest index
//           first, presenting one cell address per valid/ready handshake.
// Ports   : CLK100MHZ - clock, rising edge
//           rst       - asynchronous reset, active low
//           bus       - tag_resolver_if.slave (commands, mask, address stream)
// Build option: TAG_RESOLVER_COUNT_EN adds a registered match_count that is
//           loaded with the popcount of the captured mask and decremented on
//           every accepted address.
// -----------------------------------------------------------------------------
module tag_resolver #(
  parameter int CELL_QUANT = 512
) (
  input  logic           CLK100MHZ,
  input  logic           rst,
  tag_resolver_if.slave  bus
);
  localparam int ADDR_W = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CELL_QUANT-1:0] tag_reg_q, tag_reg_d;
  logic [CELL_QUANT-1:0] pend_q, pend_d;
  logic                  any_match_q, any_match_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
  logic                  pend_nz;
  logic [ADDR_W-1:0]     pend_idx;

  // Index 0 wins: scanning downward lets the lowest set bit overwrite last.
  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [CELL_QUANT-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = CELL_QUANT - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

  assign pend_nz  = |pend_q;
  assign pend_idx = lowest_idx(pend_q);

  always_comb begin
    state_d     = state_q;
    tag_reg_d   = tag_reg_q;
    pend_d      = pend_q;
    any_match_d = any_match_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.capture) begin
          tag_reg_d   = bus.accumulate ? (tag_reg_q | bus.tags_in) : bus.tags_in;
          any_match_d = |tag_reg_d;
        end
        if (bus.start) begin
          // tag_reg_d already reflects a same-cycle capture.
          pend_d  = tag_reg_d;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          out_valid_d = 1'b0;
          pend_d      = '0;
          state_d     = IDLE;
        end else if (!out_valid_q || bus.out_ready) begin
          // Slot is empty or being drained this cycle: refill or finish.
          if (pend_nz) begin
            out_addr_d  = pend_idx;
            // x & (x-1) clears exactly the lowest set bit, i.e. pend_idx.
            pend_d      = pend_q & (pend_q - 1'b1);
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        pend_d      = '0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tag_reg_q   <= '0;
      pend_q      <= '0;
      any_match_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_reg_q   <= tag_reg_d;
      pend_q      <= pend_d;
      any_match_q <= any_match_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign bus.tag_reg   = tag_reg_q;
  assign bus.any_match = any_match_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);

`ifdef TAG_RESOLVER_COUNT_EN
  // The extra bit lets an all-ones mask report CELL_QUANT exactly.
  function automatic logic [ADDR_W:0] popcount(input logic [CELL_QUANT-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < CELL_QUANT; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  logic [ADDR_W:0] match_count_q, match_count_d;
  logic            capture_hon;
  logic            accept;

  always_comb begin
    capture_hon   = (state_q == IDLE) && bus.capture;
    accept        = (state_q == SCAN) && !bus.abort && out_valid_q && bus.out_ready;
    match_count_d = match_count_q;
    if (capture_hon) begin
      match_count_d = popcount(tag_reg_d);
    end else if (accept) begin
      match_count_d = match_count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      match_count_q <= '0;
    end else begin
      match_count_q <= match_count_d;
    end
  end

  assign bus.match_count = match_count_q;
`endif

endmodule

// File: tb/tb_tag_resolver.sv
// -----------------------------------------------------------------------------
// tb_tag_resolver
// Purpose : directed, self-checking bench for tag_resolver. Uses an 8-cell
//           array by default and 512 cells when TAG_RESOLVER_COUNT_EN is set.
// -----------------------------------------------------------------------------
module tb_tag_resolver;
`ifdef TAG_RESOLVER_COUNT_EN
  localparam int CQ = 512;
`else
  localparam int CQ = 8;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tag_resolver_if #(.CELL_QUANT(CQ)) dut_if ();

  tag_resolver #(.CELL_QUANT(CQ)) dut (
    .CLK100MHZ (clk),
    .rst       (rst_n),
    .bus       (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    dut_if.tags_in    = '0;
    dut_if.capture    = 1'b0;
    dut_if.accumulate = 1'b0;
    dut_if.start      = 1'b0;
    dut_if.abort      = 1'b0;
    dut_if.out_ready  = 1'b0;

    // reset state
    #12;
    chk("rst_tag_reg",   64'(dut_if.tag_reg),   64'h0);
    chk("rst_any_match", 64'(dut_if.any_match), 64'h0);
    chk("rst_out_valid", 64'(dut_if.out_valid), 64'h0);
    chk("rst_out_addr",  64'(dut_if.out_addr),  64'h0);
    chk("rst_busy",      64'(dut_if.busy),      64'h0);
    chk("rst_done",      64'(dut_if.done),      64'h0);
`ifdef TAG_RESOLVER_COUNT_EN
    chk("rst_match_count", 64'(dut_if.match_count), 64'h0);
`endif
    #1;
    rst_n = 1'b1;
    step();

    // capture replace, then OR-accumulate
    dut_if.tags_in = CQ'(8'b0000_0101);
    dut_if.capture = 1'b1;
    step();
    chk("cap_replace_tag",   64'(dut_if.tag_reg),   64'h05);
    chk("cap_replace_match", 64'(dut_if.any_match), 64'h1);
    dut_if.tags_in    = CQ'(8'b1000_0000);
    dut_if.accumulate = 1'b1;
    step();
    chk("cap_or_tag",   64'(dut_if.tag_reg),   64'h85);
    chk("cap_or_match", 64'(dut_if.any_match), 64'h1);
    dut_if.capture    = 1'b0;
    dut_if.accumulate = 1'b0;
    dut_if.tags_in    = '0;

    // back-to-back walk with out_ready held high
    dut_if.out_ready = 1'b1;
    dut_if.start     = 1'b1;
    step();
    dut_if.start = 1'b0;
    chk("b2b_busy_scan",   64'(dut_if.busy),      64'h1);
    chk("b2b_valid_early", 64'(dut_if.out_valid), 64'h0);
    step();
    chk("b2b_valid0", 64'(dut_if.out_valid), 64'h1);
    chk("b2b_addr0",  64'(dut_if.out_addr),  64'h0);
    step();
    chk("b2b_addr2",  64'(dut_if.out_addr),  64'h2);
    step();
    chk("b2b_addr7",  64'(dut_if.out_addr),  64'h7);
    chk("b2b_valid7", 64'(dut_if.out_valid), 64'h1);
    step();
    chk("b2b_valid_end", 64'(dut_if.out_valid), 64'h0);
    chk("b2b_done",      64'(dut_if.done),      64'h1);
    chk("b2b_busy_end",  64'(dut_if.busy),      64'h0);
    step();
    chk("b2b_done_clr", 64'(dut_if.done),    64'h0);
    chk("b2b_tag_kept", 64'(dut_if.tag_reg), 64'h85);

    // backpressure on address 2
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    chk("bp_addr0", 64'(dut_if.out_addr), 64'h0);
    step();
    chk("bp_addr2", 64'(dut_if.out_addr), 64'h2);
    dut_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_addr",  64'(dut_if.out_addr),  64'h2);
      chk("bp_hold_valid", 64'(dut_if.out_valid), 64'h1);
    end
    dut_if.out_ready = 1'b1;
    step();
    chk("bp_resume_addr7", 64'(dut_if.out_addr), 64'h7);
    step();
    chk("bp_done", 64'(dut_if.done), 64'h1);
    step();

    // empty walk
    dut_if.tags_in = '0;
    dut_if.capture = 1'b1;
    step();
    dut_if.capture = 1'b0;
    chk("empty_any_match", 64'(dut_if.any_match), 64'h0);
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    chk("empty_valid_a", 64'(dut_if.out_valid), 64'h0);
    chk("empty_busy",    64'(dut_if.busy),      64'h1);
    step();
    chk("empty_valid_b", 64'(dut_if.out_valid), 64'h0);
    chk("empty_done",    64'(dut_if.done),      64'h1);
    step();
    chk("empty_done_clr", 64'(dut_if.done), 64'h0);

    // abort while address 2 is pending
    dut_if.tags_in = CQ'(8'b1000_0101);
    dut_if.capture = 1'b1;
    step();
    dut_if.capture = 1'b0;
    dut_if.start   = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    step();
    chk("abort_pre_addr2", 64'(dut_if.out_addr), 64'h2);
    dut_if.out_ready = 1'b0;
    dut_if.abort     = 1'b1;
    step();
    dut_if.abort = 1'b0;
    chk("abort_valid", 64'(dut_if.out_valid), 64'h0);
    chk("abort_busy",  64'(dut_if.busy),      64'h0);
    chk("abort_done",  64'(dut_if.done),      64'h0);
    step();
    chk("abort_done_later", 64'(dut_if.done), 64'h0);
    chk("abort_tag_kept",   64'(dut_if.tag_reg), 64'h85);

    // asynchronous reset in the middle of a walk
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    chk("arst_pre_valid", 64'(dut_if.out_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(dut_if.out_valid), 64'h0);
    chk("arst_tag",   64'(dut_if.tag_reg),   64'h0);
    chk("arst_busy",  64'(dut_if.busy),      64'h0);
    chk("arst_match", 64'(dut_if.any_match), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_idle_busy",  64'(dut_if.busy),      64'h0);
    chk("arst_idle_valid", 64'(dut_if.out_valid), 64'h0);

`ifdef TAG_RESOLVER_COUNT_EN
    // match counter on a full mask
    dut_if.tags_in = '1;
    dut_if.capture = 1'b1;
    step();
    dut_if.capture = 1'b0;
    chk("cnt_full", 64'(dut_if.match_count), 64'd512);
    dut_if.out_ready = 1'b1;
    dut_if.start     = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    chk("cnt_first_addr", 64'(dut_if.out_addr), 64'h0);
    step();
    step();
    step();
    chk("cnt_after3", 64'(dut_if.match_count), 64'd509);
    dut_if.out_ready = 1'b0;
    dut_if.abort     = 1'b1;
    step();
    dut_if.abort = 1'b0;
    chk("cnt_abort_kept", 64'(dut_if.match_count), 64'd509);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tag_resolver.md
Name: tag_resolver

Overview:
- Sits directly downstream of the CAM tag array in the AP datapath.
- Captures the CAM `tags` vector and holds it as a stable mask for parallel-write (`cam_mode`=1) passes.
- Serially walks the set tags, lowest index first, and emits one matching cell address per accepted handshake. The addresses drive CAM `addr_in` for readout or rewrite.

Parameters:
- CELL_QUANT, 512, number of CAM cells; width of the tag vector.
- ADDR_W, clogb2(CELL_QUANT), address width; derived localparam, not overridable.

Ports:
- CLK100MHZ  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- tags_in  input  CELL_QUANT  tag vector from CAM.
- capture  input  1  load `tags_in` into `tag_reg`; honoured in IDLE only.
- accumulate  input  1  with `capture`: 0 = replace, 1 = OR into `tag_reg`.
- start  input  1  begin address walk; honoured in IDLE only.
- abort  input  1  terminate walk, return to IDLE.
- out_ready  input  1  consumer accepts `out_addr`.
- tag_reg  output  CELL_QUANT  held tag mask; feeds CAM `cell_wea_ctrl_ap`.
- any_match  output  1  |`tag_reg`, registered.
- out_valid  output  1  `out_addr` is valid.
- out_addr  output  ADDR_W  index of current matching cell.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse on walk completion.

Behaviour:
- Reset (`rst`=0, async): state=IDLE; `tag_reg`=0, `pend`=0, `any_match`=0, `out_valid`=0, `out_addr`=0, `busy`=0, `done`=0.
- States: IDLE, SCAN, DONE.
- IDLE, `capture`=1:
  - `tag_reg` <= `accumulate` ? `tag_reg`|`tags_in` : `tags_in`.
  - Visible the next cycle; `any_match` updates in the same cycle as `tag_reg`.
- IDLE, `start`=1: `pend` <= `tag_reg`; go to SCAN.
  - If `capture` and `start` are asserted together, `pend` takes the newly captured value.
- SCAN:
  - `busy`=1.
  - If `out_valid`=0 and `pend`≠0: `out_addr` <= lowest set index of `pend`, clear that bit, `out_valid` <= 1.
  - If `out_valid`=1 and `out_ready`=1: if `pend`≠0, load the next lowest index in the same cycle (back-to-back, one address per clock). Otherwise `out_valid` <= 0 and go to DONE.
  - If `out_valid`=0 and `pend`=0 (walk started on an empty mask): go to DONE with no `out_valid` ever asserted.
  - First `out_valid` appears 2 cycles after `start` (IDLE→SCAN, then load).
  - While `out_valid`=1 and `out_ready`=0: `out_addr` and `pend` are held stable.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `abort`: in SCAN or DONE, next state is IDLE; `out_valid` <= 0, `pend` <= 0, `done` not pulsed. `abort` overrides the handshake. Ignored in IDLE.
- `tag_reg` is never modified by SCAN; it stays valid as the write mask throughout the walk.
- `capture` and `start` outside IDLE are ignored.
- Priority encoder: combinational over `pend`; index 0 has highest priority.
- Wrap: after index CELL_QUANT-1 the walk ends; no wrap-around.

Optional Feature:
- Macro: TAG_RESOLVER_COUNT_EN.
- Defined:
  - Extra output `match_count` [ADDR_W:0], registered.
  - Loaded with popcount(`tag_reg` next value) on every honoured capture; the extra bit allows CELL_QUANT to be represented when all tags are set.
  - Decrements by 1 on each accepted handshake.
  - Reset value 0. `abort` leaves it unchanged.
- Undefined: port absent, no popcount logic.

Test Plan:
- Bench uses CELL_QUANT=8 unless noted.
- Reset: assert `rst`=0 mid-walk with `out_valid`=1 -> all outputs 0 immediately (async); state IDLE after release.
- Capture replace then OR: `tags_in`=8'b0000_0101 capture, then 8'b1000_0000 with `accumulate`=1 -> `tag_reg`=8'b1000_0101, `any_match`=1.
- Back-to-back walk: `tag_reg`=8'b1000_0101, `out_ready` held 1, pulse `start` -> `out_addr` 0,2,7 on consecutive cycles starting 2 cycles after `start`; `done` pulse one cycle after last accept; `tag_reg` unchanged.
- Backpressure: same mask, `out_ready`=0 for 3 cycles on addr 2 -> `out_addr`=2, `out_valid`=1 held stable; resumes with 7 after accept.
- Empty walk and abort:
  - `tag_reg`=0, `start` -> no `out_valid`; `done` 2 cycles after `start`.
  - Separately, `abort` while `out_addr`=2 is pending -> `out_valid`=0 next cycle, no `done`, IDLE.
- TAG_RESOLVER_COUNT_EN with CELL_QUANT=512: capture all-ones -> `match_count`=512; after 3 accepts -> 509.
